line_simplifier: RTL and testbench

Parametrised line-simplification engine for the nonogram solver. It accepts one line record (all candidate fill patterns for a row or column, plus the board's current known/assigned cells for that line) and discards candidates that conflict with known cells. It derives newly determined cells from the survivors and emits the pruned record for write-back to the line FIFO. It sits between the line FIFO read port and the board-update/write-back logic, and generalises the fixed 3×3 solver path to runtime line length and option count.

---
 rtl/nonogram_pkg.sv | 30 +++
 rtl/option_checker.sv | 20 ++
 rtl/line_simplifier.sv | 226 ++++++++++++++++++++++
 tb/tb_line_simplifier.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nonogram_pkg.sv
// Shared types and default sizes for the nonogram solver datapath.
//   DEF_MAX_LEN  : default maximum cells per line
//   DEF_MAX_OPTS : default maximum candidate options per line record
//   DEF_IDX_W    : default row/column index width
//   line_rec_t   : line record header (index, orientation, length, option count, known/assigned)
//   simp_state_t : line simplifier FSM states
package nonogram_pkg;

  localparam int DEF_MAX_LEN  = 16;
  localparam int DEF_MAX_OPTS = 64;
  localparam int DEF_IDX_W    = 5;
  localparam int DEF_LEN_W    = $clog2(DEF_MAX_LEN + 1);
  localparam int DEF_CNT_W    = $clog2(DEF_MAX_OPTS + 1);

  typedef struct packed {
    logic [DEF_IDX_W-1:0]   idx;
    logic                   is_row;
    logic [DEF_LEN_W-1:0]   len;
    logic [DEF_CNT_W-1:0]   num_opts;
    logic [DEF_MAX_LEN-1:0] known;
    logic [DEF_MAX_LEN-1:0] assigned;
  } line_rec_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2
  } simp_state_t;

endpackage

// File: rtl/option_checker.sv
// Combinational consistency test of one candidate fill pattern against the
// cells already determined on the line.
//   opt        : candidate pattern, cell 0 = LSB
//   known      : 1 = cell determined
//   assigned   : value of determined cells
//   act        : active-cell mask (cells below the line length)
//   consistent : 1 when the pattern agrees with every known active cell
module option_checker #(
  parameter int LEN = 16
) (
  input  logic [LEN-1:0] opt,
  input  logic [LEN-1:0] known,
  input  logic [LEN-1:0] assigned,
  input  logic [LEN-1:0] act,
  output logic           consistent
);

  assign consistent = ((((opt & act) ^ assigned) & known & act) == '0);

endmodule

// File: rtl/line_simplifier.sv
// Line simplification engine: prunes candidate patterns of one line that
// conflict with known cells, compacts the survivors and derives newly
// determined cells (cells equal in every survivor).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | in_ready=1, capture a record on in_valid
// SCAN   | test one option per cycle, last option also writes the summary
// EMIT   | out_valid=1, hold result until out_ready
//
// Ports:
//   clk, rst                    : clock, synchronous active-low reset
//   in_valid/in_ready           : record handshake
//   in_line_idx/is_row/line_len : line identity and active length
//   in_num_opts, in_opts        : option count and packed options
//   in_known, in_assigned       : current board knowledge for the line
//   out_valid/out_ready         : result handshake
//   out_*                       : pruned record, updated knowledge, flags
//   option_counter              : option currently scanned (debug)
module line_simplifier
  import nonogram_pkg::*;
#(
  parameter int MAX_LEN  = DEF_MAX_LEN,
  parameter int MAX_OPTS = DEF_MAX_OPTS,
  parameter int IDX_W    = DEF_IDX_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IDX_W-1:0]              in_line_idx,
  input  logic                          in_is_row,
  input  logic [$clog2(MAX_LEN+1)-1:0]  in_line_len,
  input  logic [$clog2(MAX_OPTS+1)-1:0] in_num_opts,
  input  logic [MAX_OPTS*MAX_LEN-1:0]   in_opts,
  input  logic [MAX_LEN-1:0]            in_known,
  input  logic [MAX_LEN-1:0]            in_assigned,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDX_W-1:0]              out_line_idx,
  output logic                          out_is_row,
  output logic [$clog2(MAX_LEN+1)-1:0]  out_line_len,
  output logic [$clog2(MAX_OPTS+1)-1:0] out_num_opts,
  output logic [MAX_OPTS*MAX_LEN-1:0]   out_opts,
  output logic [MAX_LEN-1:0]            out_known,
  output logic [MAX_LEN-1:0]            out_assigned,
  output logic                          out_changed,
  output logic                          out_contradiction,
  output logic [$clog2(MAX_OPTS+1)-1:0] option_counter
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int CNT_W = $clog2(MAX_OPTS + 1);
  localparam int OPT_W = MAX_OPTS * MAX_LEN;

  simp_state_t state, state_nx;

  logic [MAX_LEN-1:0] act_in;
  logic [OPT_W-1:0]   opts_in_m;
  logic [CNT_W-1:0]   n_sat;

  // Captured record; opts_r shifts down one slot per SCAN cycle so the
  // option under test is always in the low slot.
  logic [OPT_W-1:0]   opts_r;
  logic [MAX_LEN-1:0] known_r;
  logic [MAX_LEN-1:0] assigned_r;
  logic [MAX_LEN-1:0] act_r;
  logic [CNT_W-1:0]   n_r;
  logic [MAX_LEN-1:0] and_acc;
  logic [MAX_LEN-1:0] or_acc;

  logic [MAX_LEN-1:0] cur_opt;
  logic               consistent;
  logic               last;
  logic [MAX_LEN-1:0] and_nx;
  logic [MAX_LEN-1:0] or_nx;
  logic [CNT_W-1:0]   num_nx;
  logic [MAX_LEN-1:0] known_fin;
  logic [MAX_LEN-1:0] assigned_fin;
  logic               contra_fin;
  logic               changed_fin;

  always_comb begin
    act_in    = '0;
    opts_in_m = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      act_in[i] = (LEN_W'(i) < in_line_len);
    end
    for (int s = 0; s < MAX_OPTS; s++) begin
      opts_in_m[s*MAX_LEN +: MAX_LEN] = in_opts[s*MAX_LEN +: MAX_LEN] & act_in;
    end
    n_sat = (in_num_opts > CNT_W'(MAX_OPTS)) ? CNT_W'(MAX_OPTS) : in_num_opts;
  end

  assign cur_opt = opts_r[MAX_LEN-1:0];
  assign last    = ((option_counter + CNT_W'(1)) == n_r);

  option_checker #(
    .LEN (MAX_LEN)
  ) u_checker (
    .opt        (cur_opt),
    .known      (known_r),
    .assigned   (assigned_r),
    .act        (act_r),
    .consistent (consistent)
  );

  // Summary of the record as it would stand if the current option were the
  // last one; only registered on the final SCAN cycle.
  always_comb begin
    and_nx       = consistent ? (and_acc & cur_opt) : and_acc;
    or_nx        = consistent ? (or_acc | cur_opt) : or_acc;
    num_nx       = out_num_opts + {{(CNT_W-1){1'b0}}, consistent};
    contra_fin   = (num_nx == '0);
    known_fin    = known_r;
    assigned_fin = assigned_r;
    if (!contra_fin) begin
      known_fin    = (known_r | and_nx | ~or_nx) & act_r;
      assigned_fin = (assigned_r & known_r) | and_nx;
    end
    changed_fin  = (known_fin != known_r) || (num_nx != n_r);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = (n_sat == '0) ? S_EMIT : S_SCAN;
        end
      end
      S_SCAN: begin
        if (last) begin
          state_nx = S_EMIT;
        end
      end
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      opts_r            <= '0;
      known_r           <= '0;
      assigned_r        <= '0;
      act_r             <= '0;
      n_r               <= '0;
      and_acc           <= '0;
      or_acc            <= '0;
      option_counter    <= '0;
      out_line_idx      <= '0;
      out_is_row        <= 1'b0;
      out_line_len      <= '0;
      out_num_opts      <= '0;
      out_opts          <= '0;
      out_known         <= '0;
      out_assigned      <= '0;
      out_changed       <= 1'b0;
      out_contradiction <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          option_counter <= '0;
          if (in_valid) begin
            out_line_idx      <= in_line_idx;
            out_is_row        <= in_is_row;
            out_line_len      <= in_line_len;
            opts_r            <= opts_in_m;
            known_r           <= in_known & act_in;
            assigned_r        <= in_assigned & act_in;
            act_r             <= act_in;
            n_r               <= n_sat;
            and_acc           <= act_in;
            or_acc            <= '0;
            out_num_opts      <= '0;
            out_opts          <= '0;
            // Already final when the record carries no options.
            out_known         <= in_known & act_in;
            out_assigned      <= in_assigned & act_in;
            out_changed       <= 1'b0;
            out_contradiction <= (n_sat == '0);
          end
        end
        S_SCAN: begin
          opts_r       <= opts_r >> MAX_LEN;
          and_acc      <= and_nx;
          or_acc       <= or_nx;
          out_num_opts <= num_nx;
          for (int s = 0; s < MAX_OPTS; s++) begin
            if (consistent && (out_num_opts == CNT_W'(s))) begin
              out_opts[s*MAX_LEN +: MAX_LEN] <= cur_opt;
            end
          end
          if (last) begin
            option_counter    <= '0;
            out_known         <= known_fin;
            out_assigned      <= assigned_fin;
            out_changed       <= changed_fin;
            out_contradiction <= contra_fin;
          end else begin
            option_counter <= option_counter + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_simplifier.sv
module tb_line_simplifier;
  import nonogram_pkg::*;

  localparam int ML = 16;
  localparam int MO = 64;
  localparam int OW = ML * MO;

  typedef struct {
    line_rec_t       rec;
    logic [OW-1:0]   opts;
    logic            changed;
    logic            contra;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_line_idx = '0;
  logic          in_is_row = 1'b0;
  logic [4:0]    in_line_len = '0;
  logic [6:0]    in_num_opts = '0;
  logic [OW-1:0] in_opts = '0;
  logic [15:0]   in_known = '0;
  logic [15:0]   in_assigned = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [4:0]    out_line_idx;
  logic          out_is_row;
  logic [4:0]    out_line_len;
  logic [6:0]    out_num_opts;
  logic [OW-1:0] out_opts;
  logic [15:0]   out_known;
  logic [15:0]   out_assigned;
  logic          out_changed;
  logic          out_contradiction;
  logic [6:0]    option_counter;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  line_simplifier dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_line_idx       (in_line_idx),
    .in_is_row         (in_is_row),
    .in_line_len       (in_line_len),
    .in_num_opts       (in_num_opts),
    .in_opts           (in_opts),
    .in_known          (in_known),
    .in_assigned       (in_assigned),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_line_idx      (out_line_idx),
    .out_is_row        (out_is_row),
    .out_line_len      (out_line_len),
    .out_num_opts      (out_num_opts),
    .out_opts          (out_opts),
    .out_known         (out_known),
    .out_assigned      (out_assigned),
    .out_changed       (out_changed),
    .out_contradiction (out_contradiction),
    .option_counter    (option_counter)
  );

  task automatic chk(string tag, logic [OW-1:0] obs, logic [OW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs[255:0], exp[255:0]);
    end
  endtask

  function automatic logic [63:0] meta();
    return 64'({out_line_idx, out_is_row, out_line_len, out_num_opts,
                out_known, out_assigned, out_changed, out_contradiction});
  endfunction

  function automatic line_rec_t mkrec(int idx, int row, int len, int n,
                                      logic [15:0] k, logic [15:0] a);
    line_rec_t r;
    r.idx      = 5'(idx);
    r.is_row   = 1'(row);
    r.len      = 5'(len);
    r.num_opts = 7'(n);
    r.known    = k;
    r.assigned = a;
    return r;
  endfunction

  function automatic exp_t mkexp(line_rec_t r, int num, logic [OW-1:0] o,
                                 logic [15:0] k, logic [15:0] a, logic ch, logic ct);
    exp_t e;
    e.rec          = r;
    e.rec.num_opts = 7'(num);
    e.rec.known    = k;
    e.rec.assigned = a;
    e.opts         = o;
    e.changed      = ch;
    e.contra       = ct;
    return e;
  endfunction

  // Reference behaviour of the line filter.
  function automatic exp_t model(line_rec_t r, logic [OW-1:0] opts);
    exp_t        e;
    logic [15:0] act, k, a, andv, orv, o;
    int          n, cnt;
    act    = 16'((32'd1 << r.len) - 32'd1);
    n      = (int'(r.num_opts) > MO) ? MO : int'(r.num_opts);
    k      = r.known & act;
    a      = r.assigned & act;
    andv   = act;
    orv    = '0;
    cnt    = 0;
    e.opts = '0;
    for (int i = 0; i < n; i++) begin
      o = opts[i*ML +: ML] & act;
      if (((o ^ a) & k) == 16'h0) begin
        e.opts[cnt*ML +: ML] = o;
        cnt++;
        andv &= o;
        orv  |= o;
      end
    end
    e.rec          = r;
    e.rec.num_opts = 7'(cnt);
    if (cnt == 0) begin
      e.contra       = 1'b1;
      e.rec.known    = k;
      e.rec.assigned = a;
    end else begin
      e.contra       = 1'b0;
      e.rec.known    = (k | andv | ~orv) & act;
      e.rec.assigned = (a & k) | andv;
    end
    e.changed = (e.rec.known != k) || (cnt != n);
    return e;
  endfunction

  task automatic drive_in(line_rec_t r, logic [OW-1:0] opts);
    in_line_idx = r.idx;
    in_is_row   = r.is_row;
    in_line_len = r.len;
    in_num_opts = r.num_opts;
    in_opts     = opts;
    in_known    = r.known;
    in_assigned = r.assigned;
  endtask

  // Returns just after the accept edge.
  task automatic send(line_rec_t r, logic [OW-1:0] opts, exp_t e, bit push);
    int guard = 0;
    @(negedge clk);
    drive_in(r, opts);
    in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_wait", 32'(guard < 200), 32'd1);
    @(posedge clk);
    if (push) sb.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic receive(int stall, int exp_lat);
    int            k = 0;
    exp_t          e;
    logic [OW-1:0] snap_o;
    logic [63:0]   snap_m;
    @(negedge clk);
    while (!out_valid && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("out_valid_seen", out_valid, 1'b1);
    if (exp_lat > 0) chk("latency", k + 1, exp_lat);
    snap_o = out_opts;
    snap_m = meta();
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("hold_opts", out_opts, snap_o);
      chk("hold_meta", meta(), snap_m);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("line_idx", out_line_idx, e.rec.idx);
      chk("is_row", out_is_row, e.rec.is_row);
      chk("line_len", out_line_len, e.rec.len);
      chk("num_opts", out_num_opts, e.rec.num_opts);
      chk("opts", out_opts, e.opts);
      chk("known", out_known, e.rec.known);
      chk("assigned", out_assigned, e.rec.assigned);
      chk("changed", out_changed, e.changed);
      chk("contradiction", out_contradiction, e.contra);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_out_valid", out_valid, 1'b0);
    chk("post_in_ready", in_ready, 1'b1);
    chk("post_counter", option_counter, 7'd0);
  endtask

  task automatic gen(int len, int n, output line_rec_t r, output logic [OW-1:0] o);
    logic [15:0] k, a, v;
    k = 16'($urandom);
    a = 16'($urandom);
    o = '0;
    for (int i = 0; i < n && i < MO; i++) begin
      v = 16'($urandom);
      if (i % 2 == 0) v = (v & ~k) | (a & k);
      o[i*ML +: ML] = v;
    end
    r = mkrec($urandom_range(0, 31), $urandom_range(0, 1), len, n, k, a);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    line_rec_t     r, r2;
    logic [OW-1:0] o, o2;
    exp_t          e;
    logic          saw_valid;

    // reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_num_opts", out_num_opts, 7'd0);
    chk("rst_opts", out_opts, '0);
    chk("rst_meta", meta(), 64'd0);
    chk("rst_counter", option_counter, 7'd0);
    @(negedge clk);
    rst = 1'b1;

    // single survivor fixes the whole line
    o = '0; o[15:0] = 16'b100; o[31:16] = 16'b010; o[47:32] = 16'b001;
    r = mkrec(3, 1, 3, 3, 16'b010, 16'b010);
    e = mkexp(r, 1, OW'(16'b010), 16'b111, 16'b010, 1'b1, 1'b0);
    send(r, o, e, 1'b1);
    receive(0, 4);

    // all survive, only the always-empty cell becomes known
    o = '0; o[15:0] = 16'b000; o[31:16] = 16'b010; o[47:32] = 16'b001;
    r = mkrec(9, 0, 3, 3, 16'b000, 16'b000);
    o2 = '0; o2[31:16] = 16'b010; o2[47:32] = 16'b001;
    e = mkexp(r, 3, o2, 16'b100, 16'b000, 1'b1, 1'b0);
    send(r, o, e, 1'b1);
    receive(0, 4);

    // no survivor: contradiction, knowledge unchanged
    o = '0; o[15:0] = 16'b100; o[31:16] = 16'b001;
    r = mkrec(1, 1, 3, 2, 16'b010, 16'b010);
    e = mkexp(r, 0, '0, 16'b010, 16'b010, 1'b1, 1'b1);
    send(r, o, e, 1'b1);
    receive(0, 3);

    // empty record goes straight to EMIT
    r = mkrec(4, 0, 4, 0, 16'b0101, 16'b0100);
    e = mkexp(r, 0, '0, 16'b0101, 16'b0100, 1'b0, 1'b1);
    send(r, '0, e, 1'b1);
    receive(0, 1);

    // cells beyond the line length never leak to the outputs
    o = '0; o[15:0] = 16'hFFF5; o[31:16] = 16'h80AA; o[47:32] = 16'hE011;
    r = mkrec(7, 0, 5, 3, 16'hF001, 16'hFFFF);
    o2 = '0; o2[15:0] = 16'h0015; o2[31:16] = 16'h0011;
    e = mkexp(r, 2, o2, 16'h001B, 16'h0011, 1'b1, 1'b0);
    send(r, o, e, 1'b1);
    receive(0, 4);

    // feeding the result back is a fixed point
    o = '0; o[15:0] = 16'hFF15; o[31:16] = 16'hA011;
    r = mkrec(7, 0, 5, 2, 16'h801B, 16'hF011);
    e = mkexp(r, 2, o2, 16'h001B, 16'h0011, 1'b0, 1'b0);
    send(r, o, e, 1'b1);
    receive(0, 3);

    // back-pressure with a second record waiting, then a saturated count
    gen(8, 5, r, o);
    send(r, o, model(r, o), 1'b1);
    gen(16, 64, r2, o2);
    r2.num_opts = 7'd100;
    drive_in(r2, o2);
    in_valid = 1'b1;
    receive(10, 6);
    @(posedge clk);
    sb.push_back(model(r2, o2));
    #1;
    in_valid = 1'b0;
    receive(0, 65);

    // reset on the third SCAN cycle aborts the record
    gen(10, 6, r, o);
    send(r, o, e, 1'b0);
    @(negedge clk);
    chk("scan_counter_first", option_counter, 7'd0);
    @(negedge clk);
    @(negedge clk);
    chk("scan_counter_third", option_counter, 7'd2);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_counter", option_counter, 7'd0);
    chk("abort_meta", meta(), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    saw_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    chk("abort_no_valid", saw_valid, 1'b0);

    o = '0; o[15:0] = 16'b100; o[31:16] = 16'b010; o[47:32] = 16'b001;
    r = mkrec(3, 1, 3, 3, 16'b010, 16'b010);
    e = mkexp(r, 1, OW'(16'b010), 16'b111, 16'b010, 1'b1, 1'b0);
    send(r, o, e, 1'b1);
    receive(0, 4);

    // random records against the reference model
    for (int t = 0; t < 6; t++) begin
      int len, n;
      len = $urandom_range(1, 16);
      n   = $urandom_range(1, 12);
      gen(len, n, r, o);
      send(r, o, model(r, o), 1'b1);
      receive(t % 3, n + 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
